// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: memory map, exception codes and small helpers.
package mips_defs;

    // Fetch-side memory map
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT  = 32'h0000_6FFC;

    // CP0 exception codes
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Squashed instruction slot
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // 32-bit address increment; carry out is intentionally discarded so the PC wraps
    function automatic logic [31:0] pc_add(input logic [31:0] pc, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, pc} + {1'b0, inc};
        return sum[31:0];
    endfunction

endpackage

// File: rtl/f_addr_check.sv
// Fetch address checker: flags misaligned or out-of-range instruction fetches (AdEL).
module f_addr_check
    import mips_defs::*;
#(
    parameter logic [31:0] LO_ADDR = IM_BASE,
    parameter logic [31:0] HI_ADDR = IM_LIMIT
) (
    input  logic [31:0] pc,
    output logic        adel
);

    logic misaligned_s;
    logic below_s;
    logic above_s;

    // Classify the fetch address: word alignment and inclusive window [LO_ADDR, HI_ADDR]
    always_comb begin
        misaligned_s = 1'b0;
        below_s      = 1'b0;
        above_s      = 1'b0;
        if (pc[1:0] != 2'b00) begin
            misaligned_s = 1'b1;
        end else begin
            misaligned_s = 1'b0;
        end
        if (pc < LO_ADDR) begin
            below_s = 1'b1;
        end else begin
            below_s = 1'b0;
        end
        if (pc > HI_ADDR) begin
            above_s = 1'b1;
        end else begin
            above_s = 1'b0;
        end
    end

    assign adel = misaligned_s | below_s | above_s;

endmodule

// File: rtl/f_stage_pc.sv
// Fetch-stage program counter: PC register, next-PC selection and F-stage outputs.
module f_stage_pc
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC_P  = RESET_PC,
    parameter logic [31:0] EXC_ENTRY_P = EXC_ENTRY,
    parameter logic [31:0] IM_BASE_P   = IM_BASE,
    parameter logic [31:0] IM_LIMIT_P  = IM_LIMIT,
    parameter logic [4:0]  EXC_ADEL_P  = EXC_ADEL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        F_en,
    input  logic        D_eret,
    input  logic [31:0] EPC,
    input  logic        D_redirect,
    input  logic [31:0] D_target,
    input  logic        D_is_bj,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] F_instr,
    output logic [31:0] F_PC,
    output logic [31:0] F_PC_plus8,
    output logic [4:0]  F_ExcCode,
    output logic        F_BD
);

    logic [31:0] pc_r;
    logic [31:0] next_pc_s;
    logic        adel_s;

    // Address error detection on the current fetch address
    f_addr_check #(
        .LO_ADDR (IM_BASE_P),
        .HI_ADDR (IM_LIMIT_P)
    ) u_addr_check (
        .pc   (pc_r),
        .adel (adel_s)
    );

    // PC register; reset clears it immediately, independent of the clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r <= RESET_PC_P;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // Next-PC priority: exception entry, eret return, stall, redirect, sequential
    always_comb begin
        next_pc_s = pc_r;
        if (Req) begin
            next_pc_s = EXC_ENTRY_P;
        end else if (D_eret && F_en) begin
            // eret has no delay slot: return straight to EPC
            next_pc_s = EPC;
        end else if (!F_en) begin
            // stalled (including a frozen eret in D): hold
            next_pc_s = pc_r;
        end else if (D_redirect) begin
            next_pc_s = D_target;
        end else begin
            next_pc_s = pc_add(pc_r, 32'd4);
        end
    end

    // F-stage outputs: eret squashes the wrong-path fetch and masks its address error
    always_comb begin
        F_ExcCode = EXC_NONE;
        F_instr   = i_inst_rdata;
        F_BD      = D_is_bj;
        if (D_eret) begin
            F_ExcCode = EXC_NONE;
            F_instr   = NOP_WORD;
            F_BD      = 1'b0;
        end else if (adel_s) begin
            F_ExcCode = EXC_ADEL_P;
            F_instr   = NOP_WORD;
            F_BD      = D_is_bj;
        end else begin
            F_ExcCode = EXC_NONE;
            F_instr   = i_inst_rdata;
            F_BD      = D_is_bj;
        end
    end

    assign i_inst_addr = pc_r;
    assign F_PC        = pc_r;
    assign F_PC_plus8  = pc_add(pc_r, 32'd8);

endmodule
